float_accumulator: RTL

- Sequential IEEE-754 single-precision accumulator placed directly downstream of the combinational float multiplier.
- Consumes a stream of products and adds each one into a running sum.
- When the term flagged last has been added, it presents the sum and the term count on a valid/ready output.
- Arithmetic conventions match the multiplier: exact 32'h00000000 is the only zero, and mantissas are truncated.

---
 rtl/float_accumulator.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/float_accumulator.sv
// float_accumulator: sequential single-precision adder that sums a stream of
// float terms and presents the sum and term count on a valid/ready output.
module float_accumulator #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 25;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t              state;
    logic                acc_sign;
    logic [EXP_W-1:0]    acc_exp;
    logic [MANT_W-1:0]   acc_mant;
    logic                acc_zero;
    logic                term_sign;
    logic [EXP_W-1:0]    term_exp;
    logic [MANT_W-1:0]   term_mant;
    logic                last_q;
    logic [CNT_W-1:0]    count;

    logic                exp_ge_c;
    logic [EXP_W-1:0]    exp_diff_c;
    logic [MANT_W-1:0]   norm_mant_c;
    logic [EXP_W-1:0]    norm_exp_c;
    logic                norm_done_c;
    logic [CNT_W-1:0]    count_inc_c;

    // Truncating right shift; any difference of 24 or more flushes to zero.
    function automatic logic [MANT_W-1:0] align_shift(input logic [MANT_W-1:0] m,
                                                      input logic [EXP_W-1:0] d);
        if (d >= EXP_W'(24)) return '0;
        return m >> d;
    endfunction

    // Pack accumulator fields into IEEE-754 form; zero flag forces all-zero.
    function automatic logic [31:0] pack(input logic s, input logic [EXP_W-1:0] e,
                                         input logic [MANT_W-1:0] m, input logic z);
        if (z) return 32'h0000_0000;
        return {s, e, m[22:0]};
    endfunction

    // Exponent comparison, single normalisation step and saturating count.
    always_comb begin
        exp_ge_c    = (acc_exp >= term_exp);
        exp_diff_c  = exp_ge_c ? (acc_exp - term_exp) : (term_exp - acc_exp);
        norm_mant_c = acc_mant;
        norm_exp_c  = acc_exp;
        norm_done_c = 1'b1;
        if (!acc_zero) begin
            if (acc_mant[24]) begin
                norm_mant_c = acc_mant >> 1;
                norm_exp_c  = acc_exp + EXP_W'(1);
            end else if (!acc_mant[23]) begin
                norm_mant_c = acc_mant << 1;
                norm_exp_c  = acc_exp - EXP_W'(1);
                norm_done_c = 1'b0;
            end
        end
        count_inc_c = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
    end

    // Control FSM with datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_sign  <= 1'b0;
            acc_exp   <= '0;
            acc_mant  <= '0;
            acc_zero  <= 1'b1;
            term_sign <= 1'b0;
            term_exp  <= '0;
            term_mant <= '0;
            last_q    <= 1'b0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        term_sign <= in_data[31];
                        term_exp  <= in_data[30:23];
                        term_mant <= {2'b01, in_data[22:0]};
                        last_q    <= in_last;
                        count     <= count_inc_c;
                        if (in_data == 32'h0000_0000) begin
                            if (in_last) begin
                                state     <= OUT;
                                in_ready  <= 1'b0;
                                out_valid <= 1'b1;
                                out_data  <= pack(acc_sign, acc_exp, acc_mant, acc_zero);
                                out_count <= count_inc_c;
                            end
                        end else begin
                            state    <= ALIGN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                ALIGN: begin
                    if (acc_zero) begin
                        acc_sign <= term_sign;
                        acc_exp  <= term_exp;
                        acc_mant <= term_mant;
                        acc_zero <= 1'b0;
                        state    <= NORM;
                    end else begin
                        if (exp_ge_c) begin
                            term_mant <= align_shift(term_mant, exp_diff_c);
                        end else begin
                            acc_mant <= align_shift(acc_mant, exp_diff_c);
                            acc_exp  <= term_exp;
                        end
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (acc_sign == term_sign) begin
                        acc_mant <= acc_mant + term_mant;
                    end else if (acc_mant > term_mant) begin
                        acc_mant <= acc_mant - term_mant;
                    end else if (acc_mant < term_mant) begin
                        acc_mant <= term_mant - acc_mant;
                        acc_sign <= term_sign;
                    end else begin
                        acc_mant <= '0;
                        acc_sign <= 1'b0;
                        acc_zero <= 1'b1;
                    end
                    state <= NORM;
                end
                NORM: begin
                    acc_mant <= norm_mant_c;
                    acc_exp  <= norm_exp_c;
                    if (norm_done_c) begin
                        if (last_q) begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                            out_data  <= pack(acc_sign, norm_exp_c, norm_mant_c, acc_zero);
                            out_count <= count;
                        end else begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc_sign  <= 1'b0;
                        acc_exp   <= '0;
                        acc_mant  <= '0;
                        acc_zero  <= 1'b1;
                        count     <= '0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
